lcd_bus_decoder: RTL

//  Listens on the HD44780-style LCD bus (RS/E/DB) driven by the LCD write controller and behaves as the display side.

---
 rtl/lcd_pkg.sv | 34 +++
 rtl/lcd_bus_sync.sv | 66 ++++++
 rtl/lcd_bus_decoder.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style bus decoder: FSM states, opcode
// masks, the fill character and the default geometry/timing.
package lcd_pkg;

  localparam int DEF_DDRAM_DEPTH = 80;
  localparam int DEF_BUSY_CYCLES = 16000;

  localparam logic [7:0] SPACE_CHAR = 8'h20;

  // Instruction opcodes, identified by their highest set bit.
  localparam logic [7:0] OP_SET_DDRAM = 8'h80;
  localparam logic [7:0] OP_SET_CGRAM = 8'h40;
  localparam logic [7:0] OP_FUNC_SET  = 8'h20;
  localparam logic [7:0] OP_SHIFT     = 8'h10;
  localparam logic [7:0] OP_DISPLAY   = 8'h08;
  localparam logic [7:0] OP_ENTRY     = 8'h04;
  localparam logic [7:0] OP_HOME      = 8'h02;
  localparam logic [7:0] OP_CLEAR     = 8'h01;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_DECODE     = 2'd1,
    S_CLEAR_FILL = 2'd2
  } lcd_state_e;

  // Step the address counter by one in either direction, wrapping at both ends.
  function automatic logic [6:0] lcd_ac_step(input logic [6:0] ac,
                                             input logic       up,
                                             input logic [6:0] last);
    if (up) return (ac >= last) ? 7'd0 : ac + 7'd1;
    else    return (ac == 7'd0) ? last : ac - 7'd1;
  endfunction

endpackage

// File: rtl/lcd_bus_sync.sv
// Synchronizes the asynchronous LCD bus, detects the falling edge of E and
// presents the RS/DB values seen in the last synchronized cycle of E high.
module lcd_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_rs_i,
  input  logic       lcd_e_i,
  input  logic [7:0] lcd_db_i,
  output logic       strobe_o,
  output logic       rs_o,
  output logic [7:0] db_o
);

  logic [SYNC_STAGES-1:0]      e_sync_q;
  logic [SYNC_STAGES-1:0]      rs_sync_q;
  logic [SYNC_STAGES-1:0][7:0] db_sync_q;
  logic                        e_prev_q;
  logic                        strobe_q;
  logic                        rs_cap_q;
  logic [7:0]                  db_cap_q;

  logic       e_s;
  logic       rs_s;
  logic [7:0] db_s;

  assign e_s  = e_sync_q[SYNC_STAGES-1];
  assign rs_s = rs_sync_q[SYNC_STAGES-1];
  assign db_s = db_sync_q[SYNC_STAGES-1];

  // Synchronizer chain, edge detector and capture of the bus while E is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_sync_q  <= '0;
      rs_sync_q <= '0;
      db_sync_q <= '0;
      e_prev_q  <= 1'b0;
      strobe_q  <= 1'b0;
      rs_cap_q  <= 1'b0;
      db_cap_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample its neighbour's
      // old value, which is exactly what a shift chain needs.
      e_sync_q[0]  <= lcd_e_i;
      rs_sync_q[0] <= lcd_rs_i;
      db_sync_q[0] <= lcd_db_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        e_sync_q[i]  <= e_sync_q[i-1];
        rs_sync_q[i] <= rs_sync_q[i-1];
        db_sync_q[i] <= db_sync_q[i-1];
      end
      e_prev_q <= e_s;
      strobe_q <= e_prev_q & ~e_s;
      if (e_s) begin
        rs_cap_q <= rs_s;
        db_cap_q <= db_s;
      end
    end
  end

  assign strobe_o = strobe_q;
  assign rs_o     = rs_cap_q;
  assign db_o     = db_cap_q;

endmodule

// File: rtl/lcd_bus_decoder.sv
// Display-side model of an HD44780-style panel: decodes bus transfers,
// keeps a DDRAM mirror, exposes the panel flags and emulates busy timing.
// Optional feature: define LCD_DECODER_4BIT_EN to assemble bytes from two
// nibble strobes while DL = 0.
module lcd_bus_decoder
  import lcd_pkg::*;
#(
  parameter int DDRAM_DEPTH = DEF_DDRAM_DEPTH,
  parameter int SYNC_STAGES = 2,
  parameter int BUSY_CYCLES = DEF_BUSY_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_rs,
  input  logic       lcd_e,
  input  logic [7:0] lcd_db,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [6:0] cursor_addr,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       func_8bit,
  output logic       func_2line,
  output logic       busy,
  output logic       cmd_valid,
  output logic       cmd_is_data,
  output logic [7:0] cmd_byte,
  output logic       err_protocol
);

  localparam logic [6:0] LAST_ADDR = 7'(DDRAM_DEPTH - 1);
  localparam int         CNT_W     = $clog2(BUSY_CYCLES + 1);
  localparam logic [CNT_W-1:0] BUSY_LOAD = CNT_W'(BUSY_CYCLES);

  logic       sync_strobe;
  logic       sync_rs;
  logic [7:0] sync_db;

  lcd_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .lcd_rs_i (lcd_rs),
    .lcd_e_i  (lcd_e),
    .lcd_db_i (lcd_db),
    .strobe_o (sync_strobe),
    .rs_o     (sync_rs),
    .db_o     (sync_db)
  );

  lcd_state_e       state_q, state_d;
  logic [6:0]       ac_q, ac_d;
  logic [6:0]       fill_q, fill_d;
  logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
  logic             disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
  logic             dl_q, dl_d, n_q, n_d, id_q, id_d;
  logic             cgram_q, cgram_d, err_q, err_d;
  logic             pend_rs_q, pend_rs_d;
  logic [7:0]       pend_db_q, pend_db_d;
  logic             cmd_valid_q, cmd_valid_d, cmd_is_data_q, cmd_is_data_d;
  logic [7:0]       cmd_byte_q, cmd_byte_d;
  logic [7:0]       rd_data_q;

  logic             mem_we;
  logic [6:0]       mem_waddr;
  logic [7:0]       mem_wdata;
  logic [7:0]       mem_q [DDRAM_DEPTH];

  logic             xfer_valid;
  logic             xfer_rs;
  logic [7:0]       xfer_db;

`ifdef LCD_DECODER_4BIT_EN
  logic       nib_phase_q;
  logic [3:0] nib_hi_q;
  logic       dl_prev_q;

  // Nibble assembly in 4-bit mode; the phase restarts whenever DL changes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nib_phase_q <= 1'b0;
      nib_hi_q    <= '0;
      dl_prev_q   <= 1'b1;
    end else begin
      dl_prev_q <= dl_q;
      if (dl_prev_q != dl_q) begin
        nib_phase_q <= 1'b0;
      end else if (sync_strobe && !dl_q) begin
        if (!nib_phase_q) nib_hi_q <= sync_db[7:4];
        nib_phase_q <= ~nib_phase_q;
      end
    end
  end

  assign xfer_valid = sync_strobe && (dl_q || nib_phase_q);
  assign xfer_rs    = sync_rs;
  assign xfer_db    = dl_q ? sync_db : {nib_hi_q, sync_db[7:4]};
`else
  assign xfer_valid = sync_strobe;
  assign xfer_rs    = sync_rs;
  assign xfer_db    = sync_db;
`endif

  assign busy = (busy_cnt_q != '0) || (state_q == S_CLEAR_FILL);

  // State register and all control/flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_CLEAR_FILL;
      ac_q          <= '0;
      fill_q        <= '0;
      busy_cnt_q    <= '0;
      disp_q        <= 1'b0;
      cur_q         <= 1'b0;
      blink_q       <= 1'b0;
      dl_q          <= 1'b1;
      n_q           <= 1'b0;
      id_q          <= 1'b1;
      cgram_q       <= 1'b0;
      err_q         <= 1'b0;
      pend_rs_q     <= 1'b0;
      pend_db_q     <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_is_data_q <= 1'b0;
      cmd_byte_q    <= '0;
    end else begin
      state_q       <= state_d;
      ac_q          <= ac_d;
      fill_q        <= fill_d;
      busy_cnt_q    <= busy_cnt_d;
      disp_q        <= disp_d;
      cur_q         <= cur_d;
      blink_q       <= blink_d;
      dl_q          <= dl_d;
      n_q           <= n_d;
      id_q          <= id_d;
      cgram_q       <= cgram_d;
      err_q         <= err_d;
      pend_rs_q     <= pend_rs_d;
      pend_db_q     <= pend_db_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_is_data_q <= cmd_is_data_d;
      cmd_byte_q    <= cmd_byte_d;
    end
  end

  // Next-state logic: accept/reject strobes, decode, and sweep the clear fill.
  always_comb begin
    // NOTE: every variable gets a default here so no path can infer a latch.
    state_d       = state_q;
    ac_d          = ac_q;
    fill_d        = fill_q;
    busy_cnt_d    = (busy_cnt_q != '0) ? busy_cnt_q - 1'b1 : busy_cnt_q;
    disp_d        = disp_q;
    cur_d         = cur_q;
    blink_d       = blink_q;
    dl_d          = dl_q;
    n_d           = n_q;
    id_d          = id_q;
    cgram_d       = cgram_q;
    err_d         = err_q;
    pend_rs_d     = pend_rs_q;
    pend_db_d     = pend_db_q;
    cmd_valid_d   = 1'b0;
    cmd_is_data_d = cmd_is_data_q;
    cmd_byte_d    = cmd_byte_q;
    mem_we        = 1'b0;
    mem_waddr     = ac_q;
    mem_wdata     = pend_db_q;

    unique case (state_q)
      S_IDLE: begin
        if (xfer_valid) begin
          if (busy) begin
            err_d = 1'b1;
          end else begin
            state_d   = S_DECODE;
            pend_rs_d = xfer_rs;
            pend_db_d = xfer_db;
          end
        end
      end

      S_DECODE: begin
        state_d       = S_IDLE;
        cmd_valid_d   = 1'b1;
        cmd_is_data_d = pend_rs_q;
        cmd_byte_d    = pend_db_q;
        busy_cnt_d    = BUSY_LOAD;
        if (xfer_valid) err_d = 1'b1;
        if (pend_rs_q) begin
          // Data writes are dropped while addressing CGRAM.
          if (!cgram_q) begin
            mem_we = 1'b1;
            ac_d   = lcd_ac_step(ac_q, id_q, LAST_ADDR);
          end
        end else if ((pend_db_q & OP_SET_DDRAM) != '0) begin
          ac_d    = (pend_db_q[6:0] > LAST_ADDR) ? 7'd0 : pend_db_q[6:0];
          cgram_d = 1'b0;
        end else if ((pend_db_q & OP_SET_CGRAM) != '0) begin
          cgram_d = 1'b1;
        end else if ((pend_db_q & OP_FUNC_SET) != '0) begin
          dl_d = pend_db_q[4];
          n_d  = pend_db_q[3];
        end else if ((pend_db_q & OP_SHIFT) != '0) begin
          // Only cursor moves (S/C = 0) affect the mirror.
          if (!pend_db_q[3]) ac_d = lcd_ac_step(ac_q, pend_db_q[2], LAST_ADDR);
        end else if ((pend_db_q & OP_DISPLAY) != '0) begin
          disp_d  = pend_db_q[2];
          cur_d   = pend_db_q[1];
          blink_d = pend_db_q[0];
        end else if ((pend_db_q & OP_ENTRY) != '0) begin
          // The S bit is accepted but the mirror never shifts.
          id_d = pend_db_q[1];
        end else if ((pend_db_q & OP_HOME) != '0) begin
          ac_d    = '0;
          cgram_d = 1'b0;
        end else if ((pend_db_q & OP_CLEAR) != '0) begin
          ac_d    = '0;
          id_d    = 1'b1;
          cgram_d = 1'b0;
          fill_d  = '0;
          state_d = S_CLEAR_FILL;
        end
      end

      S_CLEAR_FILL: begin
        mem_we    = 1'b1;
        mem_waddr = fill_q;
        mem_wdata = SPACE_CHAR;
        fill_d    = fill_q + 7'd1;
        if (xfer_valid) err_d = 1'b1;
        if (fill_q == LAST_ADDR) begin
          fill_d  = '0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // DDRAM write port.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; the clear fill initialises it instead,
    // which keeps it mappable onto a plain RAM.
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // Registered DDRAM read port; out-of-range addresses read as a space.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_data_q <= '0;
    else        rd_data_q <= (rd_addr <= LAST_ADDR) ? mem_q[rd_addr] : SPACE_CHAR;
  end

  assign rd_data      = rd_data_q;
  assign cursor_addr  = ac_q;
  assign display_on   = disp_q;
  assign cursor_on    = cur_q;
  assign blink_on     = blink_q;
  assign func_8bit    = dl_q;
  assign func_2line   = n_q;
  assign cmd_valid    = cmd_valid_q;
  assign cmd_is_data  = cmd_is_data_q;
  assign cmd_byte     = cmd_byte_q;
  assign err_protocol = err_q;

endmodule
